rs1_arbiter: RTL and testbench

RS1_ARBITER -- requirements
Module: rs1_arbiter

---
 rtl/rs1_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_rs1_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rs1_arbiter.sv
// rs1_arbiter: shares a single register-file rs1 read port between the add,
// mult and muladd controllers.
//
// A requester raises its req_* level and holds it until its ack_* pulse. The
// arbiter grants one requester (round-robin ADD -> MULT -> MULADD), drives its
// select code on rs1_sel for one READ cycle, then captures rs1_rdata into
// rs1_data in RETURN and pulses the matching ack_*. A read takes 3 cycles.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   req_add/req_mult/req_muladd     level requests from the three controllers
//   rs1_rdata                       register-file data, one cycle after rs1_sel
//   rs1_sel                         select code for the rs1 address mux
//   gnt_add/gnt_mult/gnt_muladd     current owner of the rs1 port
//   ack_add/ack_mult/ack_muladd     one-cycle pulse, rs1_data valid for owner
//   rs1_data                        registered read data, held until next RETURN

// The data width normally comes from defines.vh; fall back to 32 bits when the
// macro is not already defined.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module rs1_arbiter #(
    parameter logic [1:0] ADD    = 2'b00,
    parameter logic [1:0] MULT   = 2'b01,
    parameter logic [1:0] MULADD = 2'b10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_add,
    input  logic                   req_mult,
    input  logic                   req_muladd,
    input  logic [`DATA_WIDTH-1:0] rs1_rdata,
    output logic [1:0]             rs1_sel,
    output logic                   gnt_add,
    output logic                   gnt_mult,
    output logic                   gnt_muladd,
    output logic                   ack_add,
    output logic                   ack_mult,
    output logic                   ack_muladd,
    output logic [`DATA_WIDTH-1:0] rs1_data
);

    localparam int unsigned DATA_WIDTH = `DATA_WIDTH;

    // Internal requester indices; bit positions in the req/gnt/ack vectors.
    localparam logic [1:0] IdxAdd    = 2'd0;
    localparam logic [1:0] IdxMult   = 2'd1;
    localparam logic [1:0] IdxMuladd = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        RETURN = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            sel_q, sel_d;
    logic [2:0]            gnt_q, gnt_d;
    logic [2:0]            ack_q, ack_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            ptr_q, ptr_d;   // index of the last served requester
    logic [1:0]            idx_q, idx_d;   // index of the requester in flight

    logic [2:0] req_vec;
    logic [1:0] ord0, ord1, ord2;
    logic       pick_valid;
    logic [1:0] pick_idx;

    assign req_vec = {req_muladd, req_mult, req_add};

    function automatic logic [1:0] idx_to_code(input logic [1:0] idx);
        case (idx)
            IdxAdd:  return ADD;
            IdxMult: return MULT;
            default: return MULADD;
        endcase
    endfunction

    // Round-robin search order starts at the entry after the last served one.
    always_comb begin
        case (ptr_q)
            IdxAdd: begin
                ord0 = IdxMult;
                ord1 = IdxMuladd;
                ord2 = IdxAdd;
            end
            IdxMult: begin
                ord0 = IdxMuladd;
                ord1 = IdxAdd;
                ord2 = IdxMult;
            end
            default: begin
                ord0 = IdxAdd;
                ord1 = IdxMult;
                ord2 = IdxMuladd;
            end
        endcase

        pick_valid = 1'b1;
        if (req_vec[ord0]) begin
            pick_idx = ord0;
        end else if (req_vec[ord1]) begin
            pick_idx = ord1;
        end else if (req_vec[ord2]) begin
            pick_idx = ord2;
        end else begin
            pick_valid = 1'b0;
            pick_idx   = ord0;
        end
    end

    // State register plus registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= ADD;
            gnt_q   <= 3'b000;
            ack_q   <= 3'b000;
            data_q  <= '0;
            ptr_q   <= IdxMuladd;
            idx_q   <= IdxAdd;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic. Requests are only looked at in IDLE, so req changes in
    // READ or RETURN cannot disturb the transaction in flight.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = READ;
            READ:    state_d = RETURN;
            RETURN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        sel_d  = sel_q;
        gnt_d  = gnt_q;
        ack_d  = 3'b000;
        data_d = data_q;
        ptr_d  = ptr_q;
        idx_d  = idx_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    idx_d = pick_idx;
                    sel_d = idx_to_code(pick_idx);
                    gnt_d = 3'b001 << pick_idx;
                end
            end
            READ: begin
                // Address and grant held so the register file sees a stable select.
            end
            RETURN: begin
                // Data and ack register together so the ack aligns with valid data.
                data_d = rs1_rdata;
                ack_d  = gnt_q;
                gnt_d  = 3'b000;
                ptr_d  = idx_q;
            end
            default: begin
                gnt_d = 3'b000;
            end
        endcase
    end

    assign rs1_sel    = sel_q;
    assign gnt_add    = gnt_q[IdxAdd];
    assign gnt_mult   = gnt_q[IdxMult];
    assign gnt_muladd = gnt_q[IdxMuladd];
    assign ack_add    = ack_q[IdxAdd];
    assign ack_mult   = ack_q[IdxMult];
    assign ack_muladd = ack_q[IdxMuladd];
    assign rs1_data   = data_q;

endmodule

// File: tb/tb_rs1_arbiter.sv
// Directed self-checking bench for rs1_arbiter with a scoreboard of expected
// acks. The bench models the register file: rs1_rdata is registered from
// rs1_sel one cycle after the select is presented.
module tb_rs1_arbiter;

    typedef struct packed {
        logic [2:0]  ack;
        logic [31:0] data;
    } sb_entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_add = 1'b0;
    logic        req_mult = 1'b0;
    logic        req_muladd = 1'b0;
    logic [31:0] rs1_rdata = 32'h0;
    logic [1:0]  rs1_sel;
    logic        gnt_add, gnt_mult, gnt_muladd;
    logic        ack_add, ack_mult, ack_muladd;
    logic [31:0] rs1_data;

    logic [31:0] rdata_base = 32'h0;

    int checks = 0;
    int errors = 0;

    sb_entry_t   sb[$];
    logic [2:0]  gnt_v, ack_v;
    logic [2:0]  prev_gnt = 3'b000;
    logic [1:0]  prev_sel = 2'b00;
    int          n;

    localparam logic [2:0] OhAdd    = 3'b001;
    localparam logic [2:0] OhMult   = 3'b010;
    localparam logic [2:0] OhMuladd = 3'b100;

    rs1_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_add    (req_add),
        .req_mult   (req_mult),
        .req_muladd (req_muladd),
        .rs1_rdata  (rs1_rdata),
        .rs1_sel    (rs1_sel),
        .gnt_add    (gnt_add),
        .gnt_mult   (gnt_mult),
        .gnt_muladd (gnt_muladd),
        .ack_add    (ack_add),
        .ack_mult   (ack_mult),
        .ack_muladd (ack_muladd),
        .rs1_data   (rs1_data)
    );

    always #5 clk = ~clk;

    // Register-file model: data for the presented select, one cycle later.
    always @(posedge clk) rs1_rdata <= rdata_base + {30'b0, rs1_sel};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] who, input logic [31:0] data);
        sb_entry_t e;
        e.ack  = who;
        e.data = data;
        sb.push_back(e);
    endtask

    // Advance one clock, sample 1 ns after the edge, run protocol checks and
    // pop the scoreboard on any ack.
    task automatic step();
        logic      rst_s;
        sb_entry_t e;
        rst_s = rst;
        @(posedge clk);
        #1;
        gnt_v = {gnt_muladd, gnt_mult, gnt_add};
        ack_v = {ack_muladd, ack_mult, ack_add};
        check("gnt_onehot0", 32'($onehot0(gnt_v)), 32'd1);
        check("ack_onehot0", 32'($onehot0(ack_v)), 32'd1);
        check("sel_not_11", 32'(rs1_sel != 2'b11), 32'd1);
        if (!rst_s && prev_gnt != 3'b000) begin
            check("sel_stable", 32'(rs1_sel), 32'(prev_sel));
            if (gnt_v != 3'b000) check("gnt_stable", 32'(gnt_v), 32'(prev_gnt));
        end
        if (ack_v != 3'b000) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(ack_v), 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_ack_who", 32'(ack_v), 32'(e.ack));
                check("sb_ack_data", rs1_data, e.data);
            end
        end
        prev_gnt = gnt_v;
        prev_sel = rs1_sel;
    endtask

    // Step until an ack appears or the budget runs out; returns cycles taken.
    task automatic wait_ack(input string tag, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (ack_v == 3'b000 && cyc < 12);
        check(tag, 32'(ack_v != 3'b000), 32'd1);
    endtask

    initial begin
        // Reset state.
        rst = 1'b1;
        step();
        check("rst_gnt", 32'(gnt_v), 32'd0);
        check("rst_ack", 32'(ack_v), 32'd0);
        check("rst_sel", 32'(rs1_sel), 32'd0);
        check("rst_data", rs1_data, 32'd0);
        rst = 1'b0;
        step();
        check("idle_gnt", 32'(gnt_v), 32'd0);

        // Single add request: 2 grant cycles, ack 3 cycles after sampling.
        rdata_base = 32'hA5A5_0001;
        push(OhAdd, 32'hA5A5_0001);
        req_add = 1'b1;
        step();
        check("t1_gnt_c1", 32'(gnt_v), 32'(OhAdd));
        check("t1_sel", 32'(rs1_sel), 32'd0);
        step();
        check("t1_gnt_c2", 32'(gnt_v), 32'(OhAdd));
        check("t1_noack_c2", 32'(ack_v), 32'd0);
        step();
        check("t1_ack_add", 32'(ack_add), 32'd1);
        check("t1_data", rs1_data, 32'hA5A5_0001);
        check("t1_gnt_off", 32'(gnt_v), 32'd0);
        req_add = 1'b0;
        step();
        check("t1_ack_pulse", 32'(ack_v), 32'd0);
        check("t1_data_hold", rs1_data, 32'hA5A5_0001);
        step();
        check("t1_no_regrant", 32'(gnt_v), 32'd0);

        // All three held: add, mult, muladd, add, one ack per 3 cycles.
        rst = 1'b1;
        step();
        rst = 1'b0;
        rdata_base = 32'h3000_0000;
        push(OhAdd,    32'h3000_0000);
        push(OhMult,   32'h3000_0001);
        push(OhMuladd, 32'h3000_0002);
        push(OhAdd,    32'h3000_0000);
        req_add = 1'b1;
        req_mult = 1'b1;
        req_muladd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_ack("t2_ack_seen", n);
            check("t2_ack_spacing", 32'(n), 32'd3);
        end
        req_add = 1'b0;
        req_mult = 1'b0;
        req_muladd = 1'b0;
        step();
        step();
        check("t2_drained", 32'(sb.size()), 32'd0);
        check("t2_idle_gnt", 32'(gnt_v), 32'd0);

        // Fairness: after mult is served, muladd wins over a held mult.
        rdata_base = 32'h4400_0000;
        push(OhMult, 32'h4400_0001);
        req_mult = 1'b1;
        wait_ack("t3_mult_ack", n);
        req_muladd = 1'b1;
        push(OhMuladd, 32'h4400_0002);
        push(OhMult,   32'h4400_0001);
        step();
        check("t3_fair_gnt", 32'(gnt_v), 32'(OhMuladd));
        check("t3_fair_sel", 32'(rs1_sel), 32'd2);
        wait_ack("t3_muladd_ack", n);
        wait_ack("t3_mult_ack2", n);
        req_mult = 1'b0;
        req_muladd = 1'b0;
        step();
        step();

        // Reset during READ of a mult grant aborts with no ack.
        req_mult = 1'b1;
        step();
        check("t4_gnt_mult", 32'(gnt_v), 32'(OhMult));
        check("t4_sel_mult", 32'(rs1_sel), 32'd1);
        rst = 1'b1;
        req_mult = 1'b0;
        step();
        check("t4_rst_gnt", 32'(gnt_v), 32'd0);
        check("t4_rst_ack", 32'(ack_v), 32'd0);
        check("t4_rst_sel", 32'(rs1_sel), 32'd0);
        check("t4_rst_data", rs1_data, 32'd0);

        // Request accepted right after reset; req change during READ is ignored.
        rst = 1'b0;
        req_add = 1'b1;
        rdata_base = 32'h1234_0000;
        push(OhAdd, 32'h1234_0000);
        step();
        check("t5_gnt_add", 32'(gnt_v), 32'(OhAdd));
        req_add = 1'b0;
        req_muladd = 1'b1;
        push(OhMuladd, 32'h1234_0002);
        step();
        check("t5_gnt_hold", 32'(gnt_v), 32'(OhAdd));
        check("t5_sel_hold", 32'(rs1_sel), 32'd0);
        step();
        check("t5_ack_add", 32'(ack_add), 32'd1);
        step();
        check("t5_gnt_muladd", 32'(gnt_v), 32'(OhMuladd));
        check("t5_sel_muladd", 32'(rs1_sel), 32'd2);
        wait_ack("t5_muladd_ack", n);
        check("t5_muladd_lat", 32'(n), 32'd2);
        req_muladd = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("final_drained", 32'(sb.size()), 32'd0);
        check("final_idle", 32'(gnt_v), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
